// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: alignment check, byte-enabled word access to data_mem, load extension.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
   parameter int WIDTH = 32
`ifdef LSU_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
   typedef enum logic [2:0] {
      OP_LW  = 3'b000, OP_SB  = 3'b001, OP_SH  = 3'b010, OP_SW  = 3'b011,
      OP_LB  = 3'b100, OP_LH  = 3'b101, OP_LBU = 3'b110, OP_LHU = 3'b111
   } op_e;

   state_e           state;
   op_e              op_q;
   logic [1:0]       addr_lo;
   op_e              req_op_e;
   logic             misaligned;
   logic             is_store;
   logic [3:0]       be_next;
   logic [WIDTH-1:0] wdata_next;
   logic [7:0]       lane_byte;
   logic [15:0]      lane_half;
   logic [WIDTH-1:0] load_data;

`ifdef LSU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer;
`endif

   assign req_op_e = op_e'(req_op);

   always_comb begin
      misaligned = 1'b0;
      is_store   = 1'b0;
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      case (req_op_e)
         OP_SB: begin
            is_store   = 1'b1;
            be_next    = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         OP_SH: begin
            is_store   = 1'b1;
            be_next    = 4'b0011 << req_addr[1:0];
            wdata_next = {2{req_wdata[15:0]}};
            misaligned = req_addr[0];
         end
         OP_SW: begin
            is_store   = 1'b1;
            misaligned = |req_addr[1:0];
         end
         OP_LW:         misaligned = |req_addr[1:0];
         OP_LH, OP_LHU: misaligned = req_addr[0];
         default: ;
      endcase
   end

   // Lane selection uses the offset latched at accept, since req_addr may change while in BUS.
   always_comb begin
      case (addr_lo)
         2'd0:    lane_byte = mem_rdata[7:0];
         2'd1:    lane_byte = mem_rdata[15:8];
         2'd2:    lane_byte = mem_rdata[23:16];
         default: lane_byte = mem_rdata[31:24];
      endcase
      lane_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q)
         OP_LW:   load_data = mem_rdata;
         OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_data = {24'd0, lane_byte};
         OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_data = {16'd0, lane_half};
         default: load_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         op_q       <= OP_LW;
         addr_lo    <= 2'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= 4'd0;
         mem_wdata  <= '0;
`ifdef LSU_TIMEOUT_EN
         timer      <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op_e;
                  addr_lo   <= req_addr[1:0];
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state     <= BUS;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
                     mem_be    <= be_next;
                     mem_wdata <= wdata_next;
`ifdef LSU_TIMEOUT_EN
                     timer     <= '0;
`endif
                  end
               end
            end
            BUS: begin
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end
`ifdef LSU_TIMEOUT_EN
               else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
`endif
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized traffic against a reference model.
// Define LSU_TIMEOUT_EN for both bench and RTL to exercise the bus timeout.
module tb_load_store_unit;

   localparam logic [2:0] OP_LW  = 3'd0, OP_SB  = 3'd1, OP_SH  = 3'd2, OP_SW  = 3'd3;
   localparam logic [2:0] OP_LB  = 3'd4, OP_LH  = 3'd5, OP_LBU = 3'd6, OP_LHU = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // Reference model: plain arithmetic over the op/address rules.
   function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] addr);
      if (op == OP_LW || op == OP_SW) return (addr % 4) != 0;
      if (op == OP_SH || op == OP_LH || op == OP_LHU) return (addr % 2) != 0;
      return 1'b0;
   endfunction

   function automatic bit model_store(input logic [2:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
      int a = int'(addr % 4);
      if (op == OP_SB) return 4'(1 << a);
      if (op == OP_SH) return 4'(3 << a);
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
      if (op == OP_SB) return (wd & 32'hFF) * 32'h0101_0101;
      if (op == OP_SH) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [31:0] v;
      int a = int'(addr % 4);
      case (op)
         OP_LW: return rd;
         OP_LB, OP_LBU: begin
            v = (rd >> (8 * a)) & 32'hFF;
            if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
         end
         OP_LH, OP_LHU: begin
            v = (rd >> (16 * (a / 2))) & 32'hFFFF;
            if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
         end
         default: return 32'd0;
      endcase
   endfunction

   // One transaction from an IDLE negedge; ends at the IDLE negedge after the response.
   task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, output logic [31:0] got);
      bit          bad;
      logic [31:0] exp_rd;
      bad    = model_misaligned(op, addr);
      exp_rd = bad ? 32'd0 : model_load(op, addr, rdata);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL txn_ready op=%0d: got %b want 1", op, req_ready);
      end
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      if (!bad) begin
         for (int k = 0; k <= delay; k++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_be, req_ready, resp_valid} !==
                {1'b1, model_store(op), addr & ~32'd3, model_be(op, addr), 1'b0, 1'b0}) begin
               errors++;
               $display("[TB] FAIL bus op=%0d addr=%h k=%0d: got req=%b we=%b addr=%h be=%b rdy=%b rv=%b want req=1 we=%b addr=%h be=%b rdy=0 rv=0",
                        op, addr, k, mem_req, mem_we, mem_addr, mem_be, req_ready, resp_valid,
                        model_store(op), addr & ~32'd3, model_be(op, addr));
            end
            if (model_store(op)) begin
               checks++;
               if (mem_wdata !== model_wdata(op, wdata)) begin
                  errors++;
                  $display("[TB] FAIL wdata op=%0d: got %h want %h", op, mem_wdata, model_wdata(op, wdata));
               end
            end
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
         end
         mem_ack = 1'b0; mem_rdata = $urandom;
      end
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, bad, exp_rd, 1'b0}) begin
         errors++;
         $display("[TB] FAIL resp op=%0d addr=%h: got v=%b err=%b data=%h mreq=%b want v=1 err=%b data=%h mreq=0",
                  op, addr, resp_valid, resp_err, resp_rdata, mem_req, bad, exp_rd);
      end
      got = resp_rdata;
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b0, 1'b1, bad, exp_rd}) begin
         errors++;
         $display("[TB] FAIL after_resp op=%0d: got v=%b rdy=%b err=%b data=%h want v=0 rdy=1 err=%b data=%h",
                  op, resp_valid, req_ready, resp_err, resp_rdata, bad, exp_rd);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("[TB] FAIL reset_state: got rdy=%b rv=%b err=%b mreq=%b we=%b be=%b rd=%h ma=%h mw=%h want rdy=1 rest 0",
                  req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loads();
      logic [31:0] got;
      do_txn(OP_LB, 32'h0000_0103, $urandom, 32'h80FF_1234, 0, got);
      checks++;
      if (got !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_0x103: got %h want ffffff80", got); end
      do_txn(OP_LHU, 32'h0000_0202, $urandom, 32'h9ABC_0000, 0, got);
      checks++;
      if (got !== 32'h0000_9ABC) begin errors++; $display("[TB] FAIL lhu_0x202: got %h want 00009abc", got); end
      do_txn(OP_LH, 32'h0000_0202, $urandom, 32'h9ABC_0000, 1, got);
      checks++;
      if (got !== 32'hFFFF_9ABC) begin errors++; $display("[TB] FAIL lh_0x202: got %h want ffff9abc", got); end
   endtask

   task automatic test_stores();
      logic [31:0] got;
      do_txn(OP_SB, 32'h0000_0301, 32'h1234_56A5, $urandom, 0, got);
      checks++;
      if (got !== 32'd0) begin errors++; $display("[TB] FAIL sb_rdata: got %h want 0", got); end
      do_txn(OP_SH, 32'h0000_0302, 32'h1234_56A5, $urandom, 2, got);
      checks++;
      if (got !== 32'd0) begin errors++; $display("[TB] FAIL sh_rdata: got %h want 0", got); end
      do_txn(OP_SW, 32'h0000_0308, 32'hDEAD_BEEF, $urandom, 0, got);
   endtask

   task automatic test_misaligned();
      logic [31:0] got;
      do_txn(OP_SW, 32'h0000_0405, $urandom, $urandom, 0, got);
      do_txn(OP_LH, 32'h0000_0001, $urandom, $urandom, 0, got);
      do_txn(OP_LW, 32'h0000_0002, $urandom, $urandom, 0, got);
   endtask

   task automatic test_long_wait();
      logic [31:0] got;
      do_txn(OP_LW, 32'h0000_0504, $urandom, 32'hCAFE_F00D, 5, got);
      checks++;
      if (got !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL lw_delay: got %h want cafef00d", got); end
   endtask

   // Request held through RESP must be accepted once the unit is back in IDLE.
   task automatic test_back_to_back();
      req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0000_0405;
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_err, req_ready} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL b2b_resp: got v=%b err=%b rdy=%b want 1 1 0", resp_valid, resp_err, req_ready);
      end
      req_op = OP_LW; req_addr = 32'h0000_0800;
      @(negedge clk);
      checks++;
      if ({req_ready, mem_req, resp_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL b2b_idle: got rdy=%b mreq=%b v=%b want 1 0 0", req_ready, mem_req, resp_valid);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({mem_req, mem_addr, req_ready} !== {1'b1, 32'h0000_0800, 1'b0}) begin
         errors++;
         $display("[TB] FAIL b2b_accept: got mreq=%b addr=%h rdy=%b want 1 00000800 0", mem_req, mem_addr, req_ready);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h1357_9BDF}) begin
         errors++;
         $display("[TB] FAIL b2b_lw: got v=%b err=%b data=%h want 1 0 13579bdf", resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_bus();
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0600;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("[TB] FAIL reset_mid_bus: got rdy=%b rv=%b err=%b mreq=%b we=%b be=%b rd=%h ma=%h want rdy=1 rest 0",
                  req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, resp_rdata, mem_addr);
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL post_reset k=%0d: got v=%b mreq=%b rdy=%b want 0 0 1", k, resp_valid, mem_req, req_ready);
         end
      end
   endtask

   task automatic test_timeout();
      int bus_cycles = 0;
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0700;
      @(negedge clk);
      req_valid = 1'b0; mem_ack = 1'b0;
`ifdef LSU_TIMEOUT_EN
      while (mem_req === 1'b1 && bus_cycles < 100) begin
         bus_cycles++;
         @(negedge clk);
      end
      checks++;
      if ({bus_cycles, resp_valid, resp_err, resp_rdata} !== {32'sd16, 1'b1, 1'b1, 32'd0}) begin
         errors++;
         $display("[TB] FAIL timeout: got cycles=%0d v=%b err=%b data=%h want 16 1 1 0",
                  bus_cycles, resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
`else
      while (bus_cycles < 40) begin
         checks++;
         if ({mem_req, resp_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL no_timeout cycle=%0d: got mreq=%b v=%b want 1 0", bus_cycles, mem_req, resp_valid);
         end
         bus_cycles++;
         @(negedge clk);
      end
      mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h2468_ACE0}) begin
         errors++;
         $display("[TB] FAIL late_ack: got v=%b err=%b data=%h want 1 0 2468ace0", resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
`endif
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] got;
      for (int n = 0; n < 60; n++) begin
         op   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         do_txn(op, addr, $urandom, $urandom, int'($urandom_range(0, 3)), got);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_misaligned();
      test_long_wait();
      test_back_to_back();
      test_reset_mid_bus();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block between the core's execute stage and data_mem.
- Accepts one load/store request per transaction and checks alignment. Issues a word-aligned, byte-enabled access to data memory and waits for its acknowledge.
- Returns sign/zero-extended load data to the write-back path.
- Replaces the ad-hoc Data_read/DM_data_in registers in the core with a handshaked, multi-cycle unit.

Parameters:
- WIDTH, 32, data/address width; only 32 supported.
- TIMEOUT_CYCLES, 16, BUS-state cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request (IDLE only).
- req_op  input  3  000 LW, 001 SB, 010 SH, 011 SW, 100 LB, 101 LH, 110 LBU, 111 LHU.
- req_addr  input  WIDTH  byte address (ALU result).
- req_wdata  input  WIDTH  store data; low byte/half used for SB/SH.
- resp_valid  output  1  one-cycle pulse: transaction complete.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned (or timeout).
- mem_req  output  1  data memory access request.
- mem_we  output  1  1 = write.
- mem_addr  output  WIDTH  word address: req_addr with [1:0] forced to 00.
- mem_be  output  4  byte enables.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_ack  input  1  memory completes the access; ignored outside BUS.
- mem_rdata  input  WIDTH  read word, valid with mem_ack.

Behaviour:
- Reset (rst=0 at edge):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, mem_req, mem_we, mem_be=0; resp_rdata, mem_addr, mem_wdata=0.
  - Reset during BUS drops mem_req on that same edge; no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid=1; latch op, addr and wdata.
  - Misaligned request goes straight to RESP with err=1 and no memory access. Misaligned means: halfword op with addr[0]=1, or word op with addr[1:0]!=00.
  - Aligned request goes to BUS.
- BUS:
  - req_ready=0.
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack.
  - On mem_ack=1: loads capture the extended mem_rdata, then go to RESP.
  - mem_ack arriving in the same cycle mem_req first rises is legal.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0, so a request held during RESP is accepted the following cycle.
  - No backpressure on the response.
- Byte enables (a = addr[1:0]):
  - SB: 0001<<a.
  - SH: 0011<<a.
  - SW and all loads: 1111.
  - mem_we=1 only for SB/SH/SW.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - LB/LBU: byte lane a, sign- or zero-extended.
  - LH/LHU: half lane a[1], sign- or zero-extended.
  - LW: full word.
- Latency:
  - Aligned access with mem_ack in the first BUS cycle: accept at cycle 0, mem_req cycles 1..n, resp_valid at n+1.
  - Misaligned access: resp_valid at cycle 1.
- resp_rdata and resp_err hold their values until the next resp_valid; they are not cleared in IDLE.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to RESP with resp_err=1 and resp_rdata=0.
  - mem_ack in that same cycle wins over the timeout.
- Undefined: BUS waits indefinitely; no counter logic is present.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234, ack on first BUS cycle -> mem_addr=0x100, mem_be=1111, resp_valid at cycle 2, resp_rdata=0xFFFF_FF80, resp_err=0.
- LHU at 0x202, mem_rdata=0x9ABC_0000 -> resp_rdata=0x0000_9ABC. LH at the same address -> 0xFFFF_9ABC.
- SB at 0x301, wdata=0x1234_56A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5. SH at 0x302 -> mem_be=1100, mem_wdata=0x56A5_56A5. resp_rdata=0 for both.
- SW at 0x405 -> no mem_req ever asserted; resp_valid at cycle 1 with resp_err=1. LH at 0x001 -> same response.
- LW with mem_ack delayed 5 cycles -> mem_req, mem_addr and mem_be stable for 5 cycles; resp_valid exactly one cycle after ack; a back-to-back req_valid is accepted the cycle after resp_valid.
- Reset mid-BUS (rst=0 while mem_req=1) -> all outputs 0 and req_ready=1 after the edge, no resp_valid. With LSU_TIMEOUT_EN and no ack -> resp_err=1 after 16 BUS cycles.
